// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed byte stream into
// 16-bit words, writes them to consecutive addresses and releases the core on a good checksum.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  core_hold,
    output logic [15:0]           words_loaded,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WORD_W = 16;

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, CHECK, DONE, ERROR
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            hi_buf, hi_buf_nxt;
    logic [WORD_W-1:0]     len, len_nxt;
    logic [WORD_W-1:0]     csum, csum_nxt;
    logic [WORD_W-1:0]     rx_csum, rx_csum_nxt;
    logic                  in_ready_nxt, wr_en_nxt, core_hold_nxt, done_nxt, error_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [WORD_W-1:0]     wr_data_nxt, words_nxt;
    logic                  xfer_c;
    logic [WORD_W-1:0]     stream_word_c;

    assign xfer_c        = in_valid & in_ready;
    assign stream_word_c = {hi_buf, in_data};

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hi_buf       <= '0;
            len          <= '0;
            csum         <= '0;
            rx_csum      <= '0;
            in_ready     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= ADDR_WIDTH'(BASE_ADDR);
            wr_data      <= '0;
            core_hold    <= 1'b1;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            hi_buf       <= hi_buf_nxt;
            len          <= len_nxt;
            csum         <= csum_nxt;
            rx_csum      <= rx_csum_nxt;
            in_ready     <= in_ready_nxt;
            wr_en        <= wr_en_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
            core_hold    <= core_hold_nxt;
            words_loaded <= words_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
        end
    end

    // Next-state and next-output logic; the address advances on the edge after each strobe
    always_comb begin
        state_nxt     = state;
        hi_buf_nxt    = hi_buf;
        len_nxt       = len;
        csum_nxt      = csum;
        rx_csum_nxt   = rx_csum;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_en ? wr_addr + ADDR_WIDTH'(1) : wr_addr;
        wr_data_nxt   = wr_data;
        core_hold_nxt = core_hold;
        words_nxt     = words_loaded;
        done_nxt      = done;
        error_nxt     = error;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt     = LEN_HI;
                    core_hold_nxt = 1'b1;
                    done_nxt      = 1'b0;
                    error_nxt     = 1'b0;
                    words_nxt     = '0;
                    csum_nxt      = '0;
                    wr_addr_nxt   = ADDR_WIDTH'(BASE_ADDR);
                end
            end
            LEN_HI: begin
                if (xfer_c) begin
                    hi_buf_nxt = in_data;
                    state_nxt  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer_c) begin
                    len_nxt = stream_word_c;
                    if (32'(stream_word_c) > MAX_WORDS) begin
                        state_nxt = ERROR;
                        error_nxt = 1'b1;
                    end else if (stream_word_c == '0) begin
                        state_nxt = CSUM_HI;
                    end else begin
                        state_nxt = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer_c) begin
                    hi_buf_nxt = in_data;
                    state_nxt  = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer_c) begin
                    wr_data_nxt = stream_word_c;
                    wr_en_nxt   = 1'b1;
                    csum_nxt    = csum ^ stream_word_c;
                    words_nxt   = words_loaded + WORD_W'(1);
                    state_nxt   = (words_loaded + WORD_W'(1) == len) ? CSUM_HI : DATA_HI;
                end
            end
            CSUM_HI: begin
                if (xfer_c) begin
                    hi_buf_nxt = in_data;
                    state_nxt  = CSUM_LO;
                end
            end
            CSUM_LO: begin
                if (xfer_c) begin
                    rx_csum_nxt = stream_word_c;
                    state_nxt   = CHECK;
                end
            end
            CHECK: begin
                if (rx_csum == csum) begin
                    state_nxt     = DONE;
                    done_nxt      = 1'b1;
                    core_hold_nxt = 1'b0;
                end else begin
                    state_nxt     = ERROR;
                    error_nxt     = 1'b1;
                    core_hold_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt = (state_nxt == LEN_HI)  || (state_nxt == LEN_LO)  ||
                       (state_nxt == DATA_HI) || (state_nxt == DATA_LO) ||
                       (state_nxt == CSUM_HI) || (state_nxt == CSUM_LO);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are driven, popped on wr_en.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        core_hold;
    logic [15:0] words_loaded;
    logic        done;
    logic        error;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_wr   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] wq[$];
    logic [15:0] exp_addr;

    imem_loader #(.ADDR_WIDTH(16), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .words_loaded(words_loaded), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Write monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[31:16]));
                check("wr_data", 32'(wr_data), 32'(e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int cnt = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        if (cnt >= 100) check("ready_timeout", 32'(in_ready), 32'd1);
        tick();
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'hXX;
            tick();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = 16'd0;
    endtask

    // Streams the words in wq with their checksum (optionally corrupted)
    task automatic send_stream(input bit bad_csum, input bit gap);
        logic [15:0] n;
        logic [15:0] cs;
        n  = 16'(wq.size());
        cs = 16'd0;
        send(n[15:8], gap);
        send(n[7:0], gap);
        foreach (wq[i]) begin
            cs ^= wq[i];
            exp_q.push_back({exp_addr, wq[i]});
            exp_addr++;
            send(wq[i][15:8], gap);
            send(wq[i][7:0], gap);
        end
        if (bad_csum) cs ^= 16'h0001;
        send(cs[15:8], gap);
        send(cs[7:0], 1'b0);
        in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int cnt = 0;
        while (done !== 1'b1 && error !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        if (cnt >= 50) check("end_timeout", 32'(done | error), 32'd1);
    endtask

    task automatic check_result(input string tag, input bit ok, input int unsigned nw);
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_error"}, 32'(error), 32'(!ok));
        check({tag, "_hold"}, 32'(core_hold), 32'(!ok));
        check({tag, "_words"}, 32'(words_loaded), nw);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int unsigned w0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Two words back-to-back
        w0 = n_wr;
        wq = '{16'h1234, 16'hABCD};
        do_start();
        send_stream(1'b0, 1'b0);
        wait_end();
        check_result("b2b", 1'b1, 2);
        check("b2b_nwr", n_wr - w0, 32'd2);

        // Same stream with in_valid toggling
        w0 = n_wr;
        do_start();
        check("restart_done_clr", 32'(done), 32'd0);
        send_stream(1'b0, 1'b1);
        wait_end();
        check_result("gap", 1'b1, 2);
        check("gap_nwr", n_wr - w0, 32'd2);

        // Empty load, good then bad checksum
        w0 = n_wr;
        wq = {};
        do_start();
        send_stream(1'b0, 1'b0);
        wait_end();
        check_result("empty_ok", 1'b1, 0);
        do_start();
        send_stream(1'b1, 1'b0);
        wait_end();
        check_result("empty_bad", 1'b0, 0);
        check("empty_nwr", n_wr - w0, 32'd0);

        // Oversize count errors right after LEN_LO
        w0 = n_wr;
        do_start();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        in_valid = 1'b0;
        check("big_error", 32'(error), 32'd1);
        check("big_ready", 32'(in_ready), 32'd0);
        check("big_hold", 32'(core_hold), 32'd1);
        tick(); tick();
        check("big_nwr", n_wr - w0, 32'd0);

        // Bad checksum after one word, then recovery
        wq = '{16'h55AA};
        do_start();
        send_stream(1'b1, 1'b0);
        wait_end();
        check_result("badcs", 1'b0, 1);
        wq = '{16'h0F0F, 16'hF00D, 16'h0001};
        do_start();
        send_stream(1'b0, 1'b0);
        wait_end();
        check_result("recover", 1'b1, 3);

        // Reset after 3 of 5 words
        do_start();
        send(8'h00, 1'b0);
        send(8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] w;
            w = 16'(16'h1111 * (i + 1));
            exp_q.push_back({exp_addr, w});
            exp_addr++;
            send(w[15:8], 1'b0);
            send(w[7:0], 1'b0);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_hold", 32'(core_hold), 32'd1);
        check("midrst_words", 32'(words_loaded), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        tick();
        check("midrst_idle_ready", 32'(in_ready), 32'd0);
        wq = '{16'hCAFE, 16'hBEEF, 16'h1357, 16'h2468, 16'h8000};
        do_start();
        send_stream(1'b0, 1'b1);
        wait_end();
        check_result("full5", 1'b1, 5);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory, which the core otherwise only reads.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit words and writes them to consecutive instruction addresses.
- Verifies an XOR checksum at the end of the stream.
- Holds the core in reset until a load completes successfully.
- Sits beside top, driving the instruction memory write port and the core reset.

Parameters:
ADDR_WIDTH, 16, width of the instruction address and wr_addr.
BASE_ADDR, 0, instruction address that receives the first loaded word.
MAX_WORDS, 256, largest word count accepted; larger counts are an error.

Ports:
clk  input  1  single system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begins a load; sampled only in IDLE, DONE and ERROR.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
wr_en  output  1  instruction memory write strobe, one cycle per word.
wr_addr  output  ADDR_WIDTH  write address.
wr_data  output  16  write data.
core_hold  output  1  drives the core reset; 1 = core held.
words_loaded  output  16  number of words written in the current or last load.
done  output  1  load finished and checksum matched.
error  output  1  load aborted (oversize count or checksum mismatch).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, core_hold=1, words_loaded=0, done=0, error=0. Internal count, checksum and byte buffer are cleared.
- Reset mid-load abandons the load. Words already written stay in memory. core_hold stays 1.
- Stream format, high byte first throughout:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N pairs of DATA_HI, DATA_LO.
  - CSUM_HI, CSUM_LO: 16-bit value that must equal the XOR of all N data words.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, CHECK, DONE, ERROR.
- in_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI and CSUM_LO. It is 0 in all other states.
- Each state advances only on a transfer.
- IDLE/DONE/ERROR with start=1 goes to LEN_HI on the next cycle, and:
  - core_hold<=1, done<=0, error<=0;
  - words_loaded<=0, checksum<=0;
  - wr_addr<=BASE_ADDR.
- LEN_LO transfer:
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CSUM_HI.
  - Otherwise: go to DATA_HI.
- DATA_HI transfer: buffer the high byte.
- DATA_LO transfer, on the next edge:
  - wr_data<={hi,lo} and wr_en<=1 for exactly one cycle.
  - wr_addr holds the current word address during the strobe.
  - checksum^={hi,lo}.
  - words_loaded increments on the same edge as wr_en rises.
  - wr_addr increments on the edge after the strobe.
- After DATA_LO: go to DATA_HI if words remain, otherwise CSUM_HI.
- Back-to-back bytes (in_valid held high) are accepted every cycle with no bubbles. Peak rate is one word per two cycles.
- CSUM_LO transfer goes to CHECK. CHECK lasts one cycle and compares the received checksum with the running XOR. By then the final word's XOR is already folded in.
  - Match: go to DONE; done<=1, core_hold<=0.
  - Mismatch: go to ERROR; error<=1, core_hold=1.
- done and error are mutually exclusive and stay asserted until start or reset.
- start outside IDLE/DONE/ERROR is ignored.
- in_valid while in_ready=0 is not consumed; the source must hold the byte.
- wr_addr is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH. MAX_WORDS sizing is the integrator's responsibility.
- wr_en is never 1 outside the cycle after a DATA_LO transfer.

Test Plan:
- Reset, then start; stream 00 02 12 34 AB CD B9 F9 back-to-back → wr_en pulses at addr 0 with 0x1234 and addr 1 with 0xABCD; done=1, core_hold=0, words_loaded=2, error=0.
- Same stream with in_valid toggled every other cycle → identical writes and result; no byte lost or duplicated; wr_en pulses exactly twice.
- Stream 00 00 00 00 → no wr_en; done=1, words_loaded=0. Stream 00 00 00 01 → error=1, core_hold=1.
- Count 0x0101 with MAX_WORDS=256 → error=1 right after LEN_LO; in_ready=0; no writes.
- Stream 00 01 55 AA 55 AB (bad checksum) → one write of 0x55AA; error=1, done=0, core_hold=1. Then start and a correct stream → done=1.
- Assert reset after 3 of 5 words → state IDLE, core_hold=1, in_ready=0, words_loaded=0. Then start and a full valid load completes correctly.
